// File: rtl/adder_share_sched_if.sv
// adder_share_sched_if
// Bundles the requester and response handshakes of the shared-adder
// scheduler. The requester/consumer side uses the master modport and the
// scheduler uses the slave modport.
//   req_valid / req_ready : per-requester request handshake (ready is one-hot or zero)
//   req_a / req_b         : packed operands, requester k at [k*OP_WIDTH +: OP_WIDTH]
//   rsp_valid / rsp_ready : single response handshake
//   rsp_id                : index of the requester that owns the response
//   rsp_sum / rsp_carry   : result modulo 2^OP_WIDTH and carry out of the MSB
interface adder_share_sched_if #(
  parameter int NUM_REQ  = 4,
  parameter int OP_WIDTH = 32,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*OP_WIDTH-1:0] req_a;
  logic [NUM_REQ*OP_WIDTH-1:0] req_b;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_WIDTH-1:0]         rsp_id;
  logic [OP_WIDTH-1:0]         rsp_sum;
  logic                        rsp_carry;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );
endinterface

// File: rtl/adder_share_sched.sv
// prefix_adder
// Kogge-Stone parallel-prefix adder.
//   operand_a, operand_b : ADDER_WIDTH-bit addends
//   sum_stage            : ADDER_WIDTH-bit sum
//   carry_bka            : carry out of the MSB
// CARRY_NO selects a constant carry-in below bit 0 (0 or nonzero for 1).
module prefix_adder #(
  parameter int ADDER_WIDTH = 17,
  parameter int CARRY_NO    = 0
) (
  input  logic [ADDER_WIDTH-1:0] operand_a,
  input  logic [ADDER_WIDTH-1:0] operand_b,
  output logic [ADDER_WIDTH-1:0] sum_stage,
  output logic                   carry_bka
);
  localparam int  W      = ADDER_WIDTH;
  localparam int  LEVELS = (W > 1) ? $clog2(W) : 0;
  localparam logic CIN   = (CARRY_NO != 0);

  // Level l holds group generate/propagate spanning 2^l bits ending at bit i.
  logic [LEVELS:0][W-1:0] g_lvl;
  logic [LEVELS:0][W-1:0] p_lvl;
  logic [W:0]             carry;

  assign g_lvl[0] = operand_a & operand_b;
  assign p_lvl[0] = operand_a ^ operand_b;

  genvar l, i;
  generate
    for (l = 1; l <= LEVELS; l++) begin : g_level
      for (i = 0; i < W; i++) begin : g_bit
        if (i >= (1 << (l - 1))) begin : g_merge
          assign g_lvl[l][i] = g_lvl[l-1][i] |
                               (p_lvl[l-1][i] & g_lvl[l-1][i - (1 << (l - 1))]);
          assign p_lvl[l][i] = p_lvl[l-1][i] & p_lvl[l-1][i - (1 << (l - 1))];
        end else begin : g_pass
          assign g_lvl[l][i] = g_lvl[l-1][i];
          assign p_lvl[l][i] = p_lvl[l-1][i];
        end
      end
    end
  endgenerate

  assign carry[0]   = CIN;
  assign carry[W:1] = g_lvl[LEVELS] | (p_lvl[LEVELS] & {W{CIN}});
  assign sum_stage  = p_lvl[0] ^ carry[W-1:0];
  assign carry_bka  = carry[W];
endmodule

// adder_share_sched
// Time-shares one prefix adder between NUM_REQ requesters. Each accepted
// operation is added CHUNK_WIDTH bits per cycle, LSB chunk first, with the
// inter-chunk carry held in a register, then presented on the response port
// until consumed. Requesters are served round-robin.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : request/response handshakes (slave modport)
//   busy     : high while an operation is running or awaiting consumption
//
// state | meaning
// IDLE  | waiting for any req_valid; grants and captures operands
// RUN   | one chunk added per cycle, WORDS cycles total
// RESP  | result presented on rsp_*, held until rsp_ready
module adder_share_sched #(
  parameter int NUM_REQ     = 4,
  parameter int CHUNK_WIDTH = 16,
  parameter int WORDS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_share_sched_if.slave    bus,
  output logic                  busy
);
  localparam int OP_WIDTH = CHUNK_WIDTH * WORDS;
  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int CIDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]        last_grant;
  logic [ID_W-1:0]        id_q;
  logic [CIDX_W-1:0]      chunk_idx;
  logic                   carry_q;
  logic                   rsp_carry_q;
  logic [CHUNK_WIDTH-1:0] a_words   [WORDS];
  logic [CHUNK_WIDTH-1:0] b_words   [WORDS];
  logic [CHUNK_WIDTH-1:0] sum_words [WORDS];

  logic [OP_WIDTH-1:0]    a_arr [NUM_REQ];
  logic [OP_WIDTH-1:0]    b_arr [NUM_REQ];
  logic [OP_WIDTH-1:0]    a_sel;
  logic [OP_WIDTH-1:0]    b_sel;

  logic                   grant_found;
  logic [ID_W-1:0]        grant_idx;
  logic                   accept;
  logic                   last_chunk;
  logic [NUM_REQ-1:0]     ready_c;
  logic                   rsp_valid_c;
  logic                   busy_c;

  logic [CHUNK_WIDTH:0]   add_a;
  logic [CHUNK_WIDTH:0]   add_b;
  logic [CHUNK_WIDTH:0]   add_sum;
  logic                   add_cout;
  logic                   sum_lsb_unused;

  // Unpack requester operand slices so selection is a plain array index.
  genvar k, w;
  generate
    for (k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign a_arr[k] = bus.req_a[k*OP_WIDTH +: OP_WIDTH];
      assign b_arr[k] = bus.req_b[k*OP_WIDTH +: OP_WIDTH];
    end
    for (w = 0; w < WORDS; w++) begin : g_pack
      assign bus.rsp_sum[w*CHUNK_WIDTH +: CHUNK_WIDTH] = sum_words[w];
    end
  endgenerate

  assign a_sel = a_arr[grant_idx];
  assign b_sel = b_arr[grant_idx];

  // Round-robin: search upward from last_grant+1, wrapping, so the
  // requester just served is considered last.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int n = 1; n <= NUM_REQ; n++) begin
      cand = (int'(last_grant) + n) % NUM_REQ;
      if (!grant_found && bus.req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  assign last_chunk = (chunk_idx == CIDX_W'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_c     = '0;
    rsp_valid_c = 1'b0;
    busy_c      = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          ready_c = NUM_REQ'(1) << grant_idx;
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_chunk) begin
          state_d = RESP;
        end
      end
      RESP: begin
        busy_c      = 1'b1;
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // While reset is held the FSM sits in IDLE; keep the grant off so no
  // requester sees a phantom accept.
  assign bus.req_ready = ready_c & {NUM_REQ{~rst}};
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign busy          = busy_c;

  // The constant 1 in bit 0 of operand_a, paired with carry_q in operand_b,
  // makes bit 0 generate exactly carry_q, injecting the chunk carry-in.
  assign add_a = {a_words[chunk_idx], 1'b1};
  assign add_b = {b_words[chunk_idx], carry_q};

  prefix_adder #(
    .ADDER_WIDTH (CHUNK_WIDTH + 1),
    .CARRY_NO    (0)
  ) u_adder (
    .operand_a (add_a),
    .operand_b (add_b),
    .sum_stage (add_sum),
    .carry_bka (add_cout)
  );

  assign sum_lsb_unused = add_sum[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        a_words[i]   <= '0;
        b_words[i]   <= '0;
        sum_words[i] <= '0;
      end
      carry_q     <= 1'b0;
      rsp_carry_q <= 1'b0;
      id_q        <= '0;
      chunk_idx   <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        for (int i = 0; i < WORDS; i++) begin
          a_words[i] <= a_sel[i*CHUNK_WIDTH +: CHUNK_WIDTH];
          b_words[i] <= b_sel[i*CHUNK_WIDTH +: CHUNK_WIDTH];
        end
        id_q       <= grant_idx;
        last_grant <= grant_idx;
        chunk_idx  <= '0;
        carry_q    <= 1'b0;
      end
      if (state_q == RUN) begin
        sum_words[chunk_idx] <= add_sum[CHUNK_WIDTH:1];
        carry_q              <= add_cout;
        chunk_idx            <= chunk_idx + 1'b1;
        if (last_chunk) begin
          rsp_carry_q <= add_cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_share_sched.sv
module tb_adder_share_sched;
  localparam int NUM_REQ = 4;
  localparam int CW      = 16;
  localparam int WORDS   = 2;
  localparam int OPW     = CW * WORDS;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  adder_share_sched_if #(.NUM_REQ(NUM_REQ), .OP_WIDTH(OPW)) bus ();

  adder_share_sched #(
    .NUM_REQ     (NUM_REQ),
    .CHUNK_WIDTH (CW),
    .WORDS       (WORDS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_valid_busy: got %b%b expected 00", bus.rsp_valid, busy);
    end
    checks++;
    if (bus.rsp_sum !== 32'h0 || bus.rsp_carry !== 1'b0 || bus.rsp_id !== 2'd0) begin
      errors++; $display("FAIL reset_rsp: got sum %h carry %b id %0d expected 0 0 0",
                         bus.rsp_sum, bus.rsp_carry, bus.rsp_id);
    end
    tick();
    tick();
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_basic_add;
    tick();
    bus.req_valid    = 4'b0001;
    bus.req_a[31:0]  = 32'h0000FFFF;
    bus.req_b[31:0]  = 32'h00000001;
    bus.rsp_ready    = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL basic_grant: got %b expected 0001", bus.req_ready);
    end
    tick();
    bus.req_valid   = '0;
    bus.req_a[31:0] = 32'hDEADBEEF;
    bus.req_b[31:0] = 32'hDEADBEEF;
    #1;
    checks++;
    if (busy !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL basic_run: got busy %b valid %b ready %b expected 1 0 0000",
                         busy, bus.rsp_valid, bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL basic_latency_early: got valid %b at T+2 expected 0", bus.rsp_valid);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL basic_latency: got valid %b at T+3 expected 1", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_sum !== 32'h00010000 || bus.rsp_carry !== 1'b0 || bus.rsp_id !== 2'd0) begin
      errors++; $display("FAIL basic_result: got sum %h carry %b id %0d expected 00010000 0 0",
                         bus.rsp_sum, bus.rsp_carry, bus.rsp_id);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL basic_release: got busy %b valid %b expected 0 0", busy, bus.rsp_valid);
    end
  endtask

  task automatic test_wrap_carry;
    bus.req_valid   = 4'b0001;
    bus.req_a[31:0] = 32'hFFFFFFFF;
    bus.req_b[31:0] = 32'h00000001;
    bus.rsp_ready   = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL wrap_grant: got %b expected 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    tick();
    checks++;
    if (dut.carry_q !== 1'b1 || dut.sum_words[0] !== 16'h0000) begin
      errors++; $display("FAIL wrap_mid_carry: got carry %b chunk0 %h expected 1 0000",
                         dut.carry_q, dut.sum_words[0]);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'h00000000 || bus.rsp_carry !== 1'b1) begin
      errors++; $display("FAIL wrap_result: got valid %b sum %h carry %b expected 1 00000000 1",
                         bus.rsp_valid, bus.rsp_sum, bus.rsp_carry);
    end
    tick();
  endtask

  task automatic test_round_robin;
    int g_idx[5];
    int g_cyc[5];
    int r_id[4];
    int g_cnt;
    int r_cnt;
    g_cnt = 0;
    r_cnt = 0;
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_a     = {32'h00000040, 32'h00000030, 32'h00000020, 32'h00000010};
    bus.req_b     = {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001};
    #1;
    for (int c = 0; c < 60 && g_cnt < 5; c++) begin
      if (bus.rsp_valid && bus.rsp_ready && r_cnt < 4) begin
        r_id[r_cnt] = int'(bus.rsp_id);
        r_cnt++;
      end
      if (bus.req_ready != '0) begin
        checks++;
        if ($countones(bus.req_ready) != 1) begin
          errors++; $display("FAIL rr_onehot: got %b expected one bit set", bus.req_ready);
        end
        for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready[k]) g_idx[g_cnt] = k;
        g_cyc[g_cnt] = c;
        g_cnt++;
      end
      tick();
    end
    checks++;
    if (g_cnt != 5) begin
      errors++; $display("FAIL rr_timeout: got %0d grants expected 5", g_cnt);
    end
    for (int i = 0; i < g_cnt; i++) begin
      checks++;
      if (g_idx[i] != i % NUM_REQ) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, g_idx[i], i % NUM_REQ);
      end
    end
    for (int i = 1; i < g_cnt; i++) begin
      checks++;
      if (g_cyc[i] - g_cyc[i-1] != WORDS + 2) begin
        errors++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d",
                           i, g_cyc[i] - g_cyc[i-1], WORDS + 2);
      end
    end
    checks++;
    if (r_cnt != 4) begin
      errors++; $display("FAIL rr_responses: got %0d expected 4", r_cnt);
    end
    for (int i = 0; i < r_cnt; i++) begin
      checks++;
      if (r_id[i] != i) begin
        errors++; $display("FAIL rr_rsp_id[%0d]: got %0d expected %0d", i, r_id[i], i);
      end
    end
    bus.req_valid = '0;
    for (int c = 0; c < 20 && busy; c++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rr_drain: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_backpressure;
    // last grant was 0, so requester 2 alone gets it
    bus.req_valid    = 4'b0100;
    bus.req_a[95:64] = 32'h12345678;
    bus.req_b[95:64] = 32'h11111111;
    bus.rsp_ready    = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_grant: got %b expected 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b1111;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'h23456789 ||
          bus.rsp_carry !== 1'b0 || bus.rsp_id !== 2'd2) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid %b sum %h carry %b id %0d expected 1 23456789 0 2",
                           c, bus.rsp_valid, bus.rsp_sum, bus.rsp_carry, bus.rsp_id);
      end
      checks++;
      if (bus.req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_stall[%0d]: got ready %b busy %b expected 0000 1",
                           c, bus.req_ready, busy);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL bp_no_same_cycle_accept: got %b expected 0000", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_idle: got valid %b busy %b ready %b expected 0 0 1000",
                         bus.rsp_valid, busy, bus.req_ready);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_skip_idle;
    int g_idx[2];
    int g_cnt;
    logic got_rsp;
    logic [31:0] rsp_sum_seen;
    logic rsp_carry_seen;
    logic [1:0] rsp_id_seen;
    g_cnt          = 0;
    got_rsp        = 1'b0;
    rsp_sum_seen   = '0;
    rsp_carry_seen = 1'b0;
    rsp_id_seen    = '0;
    tick();
    bus.req_valid     = 4'b0010;
    bus.req_a[63:32]  = 32'h8000FFFF;
    bus.req_b[63:32]  = 32'h80000001;
    bus.req_a[127:96] = 32'h00000005;
    bus.req_b[127:96] = 32'h00000006;
    bus.rsp_ready     = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL skip_first_grant: got %b expected 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b1010;
    #1;
    for (int c = 0; c < 40 && g_cnt < 2; c++) begin
      if (bus.rsp_valid && !got_rsp) begin
        got_rsp        = 1'b1;
        rsp_sum_seen   = bus.rsp_sum;
        rsp_carry_seen = bus.rsp_carry;
        rsp_id_seen    = bus.rsp_id;
      end
      if (bus.req_ready != '0) begin
        for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready[k]) g_idx[g_cnt] = k;
        g_cnt++;
      end
      tick();
    end
    checks++;
    if (g_cnt != 2) begin
      errors++; $display("FAIL skip_timeout: got %0d grants expected 2", g_cnt);
    end else begin
      checks++;
      if (g_idx[0] != 3 || g_idx[1] != 1) begin
        errors++; $display("FAIL skip_order: got %0d,%0d expected 3,1", g_idx[0], g_idx[1]);
      end
    end
    checks++;
    if (!got_rsp || rsp_id_seen !== 2'd1 || rsp_sum_seen !== 32'h00010000 || rsp_carry_seen !== 1'b1) begin
      errors++; $display("FAIL skip_result: got seen %b id %0d sum %h carry %b expected 1 1 00010000 1",
                         got_rsp, rsp_id_seen, rsp_sum_seen, rsp_carry_seen);
    end
    bus.req_valid = '0;
    for (int c = 0; c < 20 && busy; c++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL skip_drain: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_run;
    logic saw_valid;
    saw_valid       = 1'b0;
    bus.req_valid   = 4'b0001;
    bus.req_a[31:0] = 32'h00001234;
    bus.req_b[31:0] = 32'h00000001;
    bus.rsp_ready   = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_run_grant: got %b expected 0001", bus.req_ready);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || dut.sum_words[0] !== 16'h1235) begin
      errors++; $display("FAIL rst_run_progress: got busy %b chunk0 %h expected 1 1235",
                         busy, dut.sum_words[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL rst_run_ctrl: got busy %b valid %b ready %b expected 0 0 0000",
                         busy, bus.rsp_valid, bus.req_ready);
    end
    checks++;
    if (bus.rsp_sum !== 32'h0 || bus.rsp_carry !== 1'b0 || bus.rsp_id !== 2'd0 ||
        dut.chunk_idx !== 1'b0 || dut.carry_q !== 1'b0) begin
      errors++; $display("FAIL rst_run_data: got sum %h carry %b id %0d idx %0d cq %b expected all 0",
                         bus.rsp_sum, bus.rsp_carry, bus.rsp_id, dut.chunk_idx, dut.carry_q);
    end
    tick();
    bus.req_valid = '0;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.rsp_valid !== 1'b0) saw_valid = 1'b1;
      tick();
    end
    checks++;
    if (saw_valid) begin
      errors++; $display("FAIL rst_run_no_rsp: got a response after reset expected none");
    end
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_run_first_grant: got %b expected 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic_add();
    test_wrap_carry();
    test_round_robin();
    test_backpressure();
    test_skip_idle();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_share_sched.md
Name: adder_share_sched

Overview:
- Sequencer/arbiter that shares one Kogge-Stone prefix adder instance between NUM_REQ requesters.
- Performs OP_WIDTH-bit additions as WORDS consecutive CHUNK_WIDTH-bit chunk additions, LSB chunk first, with the carry registered between chunks.
- Sits between the vector multiplier's partial-product accumulation clients and the single shared adder, trading latency for area.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- CHUNK_WIDTH, 16, bits added per cycle.
- WORDS, 2, chunks per operation (≥1).
- OP_WIDTH, CHUNK_WIDTH*WORDS, operand/result width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*OP_WIDTH  operand A; requester k occupies slice [k*OP_WIDTH +: OP_WIDTH].
- req_b  in  NUM_REQ*OP_WIDTH  operand B; same slicing as req_a.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns the result.
- rsp_sum  out  OP_WIDTH  A+B modulo 2^OP_WIDTH.
- rsp_carry  out  1  carry out of the MSB.
- busy  out  1  high in RUN and RESP.

Behaviour:
- Adder instance: prefix_adder with ADDER_WIDTH=CHUNK_WIDTH+1 and CARRY_NO=0.
  - operand_a = {a_chunk,1'b1}; operand_b = {b_chunk,carry_q}. This injects carry-in at bit 0.
  - Chunk result = sum_stage[CHUNK_WIDTH:1]; chunk carry = carry_bka.
  - No other adder logic in this block.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - If any req_valid is high, round-robin select g = first set index searching upward (wrapping) from last_grant+1.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the edge: capture A and B slices of g, id_q<=g, last_grant<=g, chunk_idx<=0, carry_q<=0, go to RUN.
  - If no req_valid is high: stay in IDLE, req_ready=0.
- RUN:
  - Each cycle adds chunk chunk_idx and writes the chunk result into sum_q[chunk_idx*CHUNK_WIDTH +: CHUNK_WIDTH].
  - carry_q <= chunk carry; chunk_idx increments.
  - When chunk_idx==WORDS-1, capture final carry into rsp_carry and go to RESP.
  - req_ready=0 throughout.
- RESP:
  - rsp_valid=1; rsp_id, rsp_sum and rsp_carry are held stable until rsp_ready.
  - On rsp_valid&rsp_ready go to IDLE; no new accept in the same cycle.
- Latency: accept at edge T. RUN occupies cycles T+1..T+WORDS. rsp_valid is first high in cycle T+WORDS+1. Minimum spacing between accepts is WORDS+2 cycles.
- Operand inputs are sampled only at accept; later changes have no effect.
- A requester may drop req_valid before it is accepted; this is legal.
- Fairness: the requester just served has lowest priority next time. No requester waits more than NUM_REQ-1 grants.
- Reset, including mid-RUN or mid-RESP:
  - state=IDLE, rsp_valid=0, req_ready=0, busy=0.
  - sum_q=0, rsp_carry=0, rsp_id=0, carry_q=0, chunk_idx=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - An in-flight operation is discarded with no response.
- WORDS=1: RUN lasts one cycle.
- Wrap-around: OP_WIDTH overflow appears only in rsp_carry; rsp_sum wraps.

Test Plan:
1. Defaults. req_valid=0001, a=0x0000FFFF, b=0x00000001, accept at T -> rsp_valid at T+3, rsp_sum=0x00010000, rsp_carry=0, rsp_id=0.
2. a=0xFFFFFFFF, b=0x00000001 -> rsp_sum=0x00000000, rsp_carry=1. Also check the intermediate chunk carry=1 into chunk 1.
3. req_valid=1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0. Exactly one req_ready bit per accept; accepts 4 cycles apart.
4. rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, req_ready=0000, busy=1. Then rsp_ready=1 -> IDLE next cycle.
5. After grant to requester 1, req_valid=1010 -> next grant 3, then 1.
6. Assert rst during RUN -> outputs cleared asynchronously, no response issued. After release, req_valid=1111 -> first grant 0.
